// File: rtl/mem_bist_defs.sv
// Shared definitions for the memory BIST controller: FSM state encodings and
// the default background data word.
package mem_bist_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_PATTERN = 32'hAAAA_AAAA;

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker: delays each issued read's expected word and address by the
// memory latency, then compares, counts mismatches and remembers the first one.
module mem_bist_cmp
  import mem_bist_defs::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int ERR_W      = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clr,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_exp,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              err_zero_next
);

  logic              vld_q  [RD_LATENCY];
  logic [DATA_W-1:0] exp_q  [RD_LATENCY];
  logic [ADDR_W-1:0] addr_q [RD_LATENCY];
  logic              seen_fail;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  assign mismatch = vld_q[RD_LATENCY-1] && (rd_data != exp_q[RD_LATENCY-1]);

  // Next count is exposed so the controller can register Pass on the same edge
  // as the final comparison.
  always_comb begin
    err_next = err_count;
    if (clr)
      err_next = '0;
    else if (mismatch && (err_count != {ERR_W{1'b1}}))
      err_next = err_count + 1'b1;
  end

  assign err_zero_next = (err_next == '0);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        exp_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      err_count <= '0;
      fail_addr <= '0;
      seen_fail <= 1'b0;
    end else begin
      vld_q[0]  <= issue && !clr;
      exp_q[0]  <= issue_exp;
      addr_q[0] <= issue_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1] && !clr;
        exp_q[i]  <= exp_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
      err_count <= err_next;
      if (clr) begin
        fail_addr <= '0;
        seen_fail <= 1'b0;
      end else if (mismatch && !seen_fail) begin
        fail_addr <= addr_q[RD_LATENCY-1];
        seen_fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style BIST master for a dual-port memory: write pattern, read/compare,
// write inverse, read/compare (descending), then report pass/fail.
module mem_bist_ctrl
  import mem_bist_defs::*;
#(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 32,
  parameter int                RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] PATTERN    = DATA_W'(DEFAULT_PATTERN),
  parameter int                ERR_W      = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [ERR_W-1:0]  Err_count,
  output logic [ADDR_W-1:0] Fail_addr,
  output logic              Wr_en,
  output logic [ADDR_W-1:0] Wr_addr,
  output logic [DATA_W-1:0] Mem_wr_data,
  output logic              Rd_en,
  output logic [ADDR_W-1:0] Rd_addr,
  input  logic [DATA_W-1:0] Mem_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LATENCY - 1);

  state_t            state;
  logic              phase;
  logic [ADDR_W-1:0] idx;
  logic [2:0]        dcnt;
  logic              start_ok;
  logic              err_zero_next;

  function automatic logic [DATA_W-1:0] pattern_word(input logic [ADDR_W-1:0] a,
                                                     input logic inv);
    logic [DATA_W-1:0] e;
    e = PATTERN ^ DATA_W'(a);
    return inv ? ~e : e;
  endfunction

  assign start_ok = Start && ((state == IDLE) || (state == FIN));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      phase       <= 1'b0;
      idx         <= '0;
      dcnt        <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass        <= 1'b0;
      Wr_en       <= 1'b0;
      Wr_addr     <= '0;
      Mem_wr_data <= '0;
      Rd_en       <= 1'b0;
      Rd_addr     <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start_ok) begin
            state       <= WR;
            phase       <= 1'b0;
            idx         <= '0;
            Busy        <= 1'b1;
            Done        <= 1'b0;
            Pass        <= 1'b0;
            Wr_en       <= 1'b1;
            Wr_addr     <= '0;
            Mem_wr_data <= pattern_word('0, 1'b0);
          end
        end
        WR: begin
          if (idx == LAST_ADDR) begin
            state       <= RD;
            idx         <= '0;
            Wr_en       <= 1'b0;
            Mem_wr_data <= '0;
            Rd_en       <= 1'b1;
            Rd_addr     <= phase ? LAST_ADDR : '0;
          end else begin
            idx         <= idx + 1'b1;
            Wr_addr     <= idx + 1'b1;
            Mem_wr_data <= pattern_word(idx + 1'b1, phase);
          end
        end
        RD: begin
          if (idx == LAST_ADDR) begin
            state <= DRAIN;
            dcnt  <= '0;
            Rd_en <= 1'b0;
          end else begin
            idx     <= idx + 1'b1;
            Rd_addr <= phase ? Rd_addr - 1'b1 : Rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Wait out the read latency so the last compare lands before moving on.
          if (dcnt == DRAIN_LAST) begin
            if (!phase) begin
              state       <= WR;
              phase       <= 1'b1;
              idx         <= '0;
              Wr_en       <= 1'b1;
              Wr_addr     <= '0;
              Mem_wr_data <= pattern_word('0, 1'b1);
            end else begin
              state <= FIN;
              Busy  <= 1'b0;
              Done  <= 1'b1;
              Pass  <= err_zero_next;
            end
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_bist_cmp #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY),
    .ERR_W      (ERR_W)
  ) u_cmp (
    .Clk           (Clk),
    .Rst           (Rst),
    .clr           (start_ok),
    .issue         (Rd_en),
    .issue_addr    (Rd_addr),
    .issue_exp     (pattern_word(Rd_addr, phase)),
    .rd_data       (Mem_rd_data),
    .err_count     (Err_count),
    .fail_addr     (Fail_addr),
    .err_zero_next (err_zero_next)
  );

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Built-in self-test master that drives the write and read ports of the team's dual-port memory (Wr_en/Wr_addr/Data_in, Rd_en/Rd_addr/Data_out).
- Runs a four-phase march: write pattern, read and compare, write inverse, read and compare.
- Counts mismatches and captures the first failing address.
- Sits beside each memory instance; a top-level test sequencer starts it.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, data width.
- RD_LATENCY, 1, cycles from the edge sampling Rd_en/Rd_addr to valid Mem_rd_data; range 1..4.
- PATTERN, 32'hAAAA_AAAA, base data word (DATA_W bits).
- ERR_W, 8, width of the error counter.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle start request.
- Busy  out  1  test in progress.
- Done  out  1  held high from test end until the next accepted Start.
- Pass  out  1  Done && Err_count==0.
- Err_count  out  ERR_W  saturating mismatch count.
- Fail_addr  out  ADDR_W  address of the first mismatch.
- Wr_en  out  1  memory write enable.
- Wr_addr  out  ADDR_W  memory write address.
- Mem_wr_data  out  DATA_W  drives the memory Data_in.
- Rd_en  out  1  memory read enable.
- Rd_addr  out  ADDR_W  memory read address.
- Mem_rd_data  in  DATA_W  from the memory Data_out.

Behaviour:
- Reset (Rst=0, asynchronous) forces all outputs, counters, the FSM and the compare pipeline to 0/IDLE. A reset mid-test aborts it with no residual state.
- All outputs are registered.
- Expected data: E(a) = PATTERN ^ zero-extended a. Phase 1 uses ~E(a).
- FSM states: IDLE, WR, RD, DRAIN, FIN. A phase bit p (0/1) selects the pattern polarity.
- IDLE/FIN + Start: clear Err_count, Fail_addr, Done and p; Busy=1; go to WR with addr=0.
- Start is ignored while Busy=1.
- WR: Wr_en=1, Wr_addr=addr, Mem_wr_data=E(addr) (or ~E when p=1), one address per cycle, ascending 0..DEPTH-1. Then go to RD.
- RD: Rd_en=1, one address per cycle, DEPTH cycles.
  - p=0: ascending 0..DEPTH-1.
  - p=1: descending DEPTH-1..0.
  - Then go to DRAIN.
- Wr_en and Rd_en are never high in the same cycle.
- DRAIN: RD_LATENCY cycles with no memory activity, then:
  - p=0: set p=1, go to WR.
  - p=1: go to FIN.
- FIN: Busy=0, Done=1.
- Done rises at clock edge index 4·DEPTH+2·RD_LATENCY, counting the edge that samples Start as edge 0 (66 for the defaults).
- Compare pipeline:
  - A valid/expected/address delay line RD_LATENCY deep, loaded when Rd_en is issued.
  - At the output, if valid && Mem_rd_data != expected: increment Err_count, saturating at 2**ERR_W-1.
  - If it is the first mismatch of the run, capture Fail_addr.
- Wr_addr/Rd_addr not in use hold their last value. Mem_wr_data is 0 when Wr_en=0.

Decomposition:
- Shared package/include mem_bist_defs: state encodings (IDLE=0, WR=1, RD=2, DRAIN=3, FIN=4) and the default PATTERN constant.
- Sub-module mem_bist_cmp: RD_LATENCY-deep delay line, comparator, saturating counter and first-fail capture.

Test Plan:
All scenarios use the defaults, with a behavioural dual-port memory model (registered read, 1-cycle latency) plus fault injection.
- Fault-free memory, Start pulse:
  - Busy high from edge 0.
  - Wr_en high exactly 32 cycles, Rd_en exactly 32 cycles, never both high.
  - Phase-1 reads go 15 down to 0.
  - Done at edge 66, Pass=1, Err_count=0.
- Address 5 bit 0 stuck-at-0:
  - Phase 0 expects 32'hAAAA_AAAF and fails.
  - Phase 1 expects 32'h5555_5550 and passes.
  - Result: Err_count=1, Fail_addr=5, Pass=0.
- Address bit 3 ignored by the model (8 aliases 0): each phase yields 8 mismatches (reads 0..7). Result: Err_count=16, Fail_addr=0, Pass=0.
- Start re-pulsed during RD of phase 0: ignored, Done still at edge 66.
- Start after Done: Err_count/Done clear and the test reruns with identical timing.
- Rst low during phase-1 RD: all outputs are 0 immediately. A subsequent Start completes with Pass=1 on a fault-free model.
- ERR_W=4, all data bits stuck-at-0: Err_count saturates at 15, Fail_addr=0.
